// File: rtl/n106_audio_filter.sv
// N163/N106 expansion audio: scan averager, optional low-pass, APU mix.
// Define N106_AUDIO_IIR_EN to build the first-order IIR low-pass stage.
module n106_audio_filter #(
    parameter int IN_W       = 11,
    parameter int AVG_LOG2   = 3,
    parameter int K_SHIFT    = 4,
    parameter int GAIN_SHIFT = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ce,
    input  logic            enable,
    input  logic            mute,
    input  logic [IN_W-1:0] exp_level,
    input  logic            exp_valid,
    input  logic [15:0]     apu_in,
    output logic [15:0]     audio_out,
    output logic            audio_valid
);

    localparam int ACC_W = IN_W + AVG_LOG2;
    localparam int Y_W   = IN_W + K_SHIFT;
    localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

    logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]     avg_q, avg_d;
    logic                stb_q, stb_d;
    logic [Y_W-1:0]      y_q, y_d, y_tgt, y_step;
    logic [IN_W-1:0]     yi;
    logic [15:0]         s_mix;
    logic [16:0]         sum_mix;
    logic [15:0]         out_q, out_d;
    logic                valid_q;

    assign acc_sum = acc_q + ACC_W'(exp_level);

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        avg_d = avg_q;
        stb_d = 1'b0;
        if (!enable) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (exp_valid) begin
            if (cnt_q == CNT_LAST) begin
                avg_d = acc_sum[ACC_W-1:AVG_LOG2];
                acc_d = '0;
                cnt_d = '0;
                stb_d = 1'b1;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign y_tgt = {avg_q, {K_SHIFT{1'b0}}};

`ifdef N106_AUDIO_IIR_EN
    logic [Y_W:0]        d_iir, d_bias, bias;
    logic signed [Y_W:0] step;
    logic                d_pos;

    assign d_iir  = {1'b0, y_tgt} - {1'b0, y_q};
    assign d_pos  = !d_iir[Y_W] && (d_iir != '0);
    // Positive error rounds up so y always lands exactly on the target.
    assign bias   = d_pos ? (Y_W+1)'((1 << K_SHIFT) - 1) : '0;
    assign d_bias = d_iir + bias;
    assign step   = $signed(d_bias) >>> K_SHIFT;
    assign y_step = Y_W'({1'b0, y_q} + step);
`else
    assign y_step = y_tgt;
`endif

    always_comb begin
        y_d = y_q;
        if (!enable) begin
            y_d = '0;
        end else if (stb_q) begin
            y_d = y_step;
        end
    end

    assign yi = IN_W'(y_q >> K_SHIFT);

    always_comb begin
        s_mix = '0;
        if (!mute && enable) begin
            s_mix = 16'(yi) << GAIN_SHIFT;
        end
        sum_mix = {1'b0, apu_in} + {1'b0, s_mix};
        out_d   = out_q;
        if (ce) begin
            out_d = sum_mix[16] ? 16'hFFFF : sum_mix[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            avg_q   <= '0;
            stb_q   <= 1'b0;
            y_q     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            avg_q   <= avg_d;
            stb_q   <= stb_d;
            y_q     <= y_d;
            out_q   <= out_d;
            valid_q <= ce;
        end
    end

    assign audio_out   = out_q;
    assign audio_valid = valid_q;

endmodule

// File: tb/tb_n106_audio_filter.sv
// Scoreboard bench for n106_audio_filter: directed scans, mix and clear cases.
`timescale 1ns/1ps
module tb_n106_audio_filter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        enable;
    logic        mute;
    logic [10:0] exp_level;
    logic        exp_valid;
    logic [15:0] apu_in;
    logic [15:0] audio_out;
    logic        audio_valid;

    always #5 clk = ~clk;

    n106_audio_filter dut (
        .clk(clk),
        .reset_n(reset_n),
        .ce(ce),
        .enable(enable),
        .mute(mute),
        .exp_level(exp_level),
        .exp_valid(exp_valid),
        .apu_in(apu_in),
        .audio_out(audio_out),
        .audio_valid(audio_valid)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] sb_q[$];

    int m_acc, m_cnt, m_avg, m_y;
    bit m_stb;

    function automatic int iir(int y, int avg);
        int tgt = avg * 16;
        int d = tgt - y;
`ifdef N106_AUDIO_IIR_EN
        if (d > 0) return y + (d + 15) / 16;
        if (d < 0) return y - ((-d + 15) / 16);
        return y;
`else
        if (d != 0) return tgt;
        return y;
`endif
    endfunction

    function automatic logic [15:0] mix(logic [15:0] apu);
        int e = (mute || !enable) ? 0 : (m_y >> 4);
        int s = int'(apu) + (e << 5);
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    task automatic model_reset();
        m_acc = 0;
        m_cnt = 0;
        m_avg = 0;
        m_y   = 0;
        m_stb = 0;
    endtask

    task automatic advance();
        int n_y, n_acc, n_cnt, n_avg, sum;
        bit n_stb;
        n_y = m_y;
        if (!enable) n_y = 0;
        else if (m_stb) n_y = iir(m_y, m_avg);
        n_acc = m_acc;
        n_cnt = m_cnt;
        n_avg = m_avg;
        n_stb = 0;
        if (!enable) begin
            n_acc = 0;
            n_cnt = 0;
        end else if (exp_valid) begin
            sum = m_acc + int'(exp_level);
            if (m_cnt == 7) begin
                n_avg = sum >> 3;
                n_acc = 0;
                n_cnt = 0;
                n_stb = 1;
            end else begin
                n_acc = sum;
                n_cnt = m_cnt + 1;
            end
        end
        @(posedge clk);
        #1;
        m_y = n_y;
        m_acc = n_acc;
        m_cnt = n_cnt;
        m_avg = n_avg;
        m_stb = n_stb;
        exp_valid = 1'b0;
        ce = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) advance();
    endtask

    task automatic pulse(logic [10:0] lvl);
        exp_level = lvl;
        exp_valid = 1'b1;
        advance();
    endtask

    task automatic scan(logic [10:0] lvl);
        repeat (8) pulse(lvl);
    endtask

    task automatic ce_mdl(logic [15:0] apu);
        apu_in = apu;
        ce = 1'b1;
        sb_q.push_back(mix(apu));
        advance();
    endtask

    task automatic ce_chk(logic [15:0] apu, logic [15:0] expv);
        apu_in = apu;
        ce = 1'b1;
        sb_q.push_back(expv);
        advance();
    endtask

    task automatic settle(logic [10:0] lvl);
        repeat (200) begin
            scan(lvl);
            idle(1);
            ce_mdl(16'h0000);
        end
    endtask

    task automatic chk(string name, logic [15:0] got, logic [15:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, expv);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [15:0] e;
        if (reset_n && audio_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid got %h expected none", audio_out);
            end else begin
                e = sb_q.pop_front();
                if (audio_out !== e) begin
                    errors++;
                    $display("FAIL audio_out got %h expected %h", audio_out, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        ce = 1'b0;
        enable = 1'b1;
        mute = 1'b0;
        exp_level = '0;
        exp_valid = 1'b0;
        apu_in = '0;
        model_reset();

        repeat (4) begin
            @(posedge clk);
            #1;
            ce = 1'($urandom);
            enable = 1'($urandom);
            mute = 1'($urandom);
            exp_level = 11'($urandom);
            exp_valid = 1'($urandom);
            apu_in = 16'($urandom);
            @(negedge clk);
            chk("rst_out", audio_out, 16'h0000);
            chk("rst_valid", 16'(audio_valid), 16'h0000);
        end
        @(posedge clk);
        #1;
        ce = 1'b0;
        enable = 1'b1;
        mute = 1'b0;
        exp_valid = 1'b0;
        apu_in = '0;
        reset_n = 1'b1;
        idle(2);

        ce_chk(16'h1234, 16'h1234);
        idle(2);

        for (int i = 0; i < 8; i++) pulse(11'(i));
        ce_chk(16'h0000, 16'h0000);
        ce_mdl(16'h0000);

        pulse(11'h100);
        repeat (7) pulse(11'h000);
        idle(1);
        ce_mdl(16'h0000);

        settle(11'h400);
        ce_chk(16'h0000, 16'h8000);

        settle(11'h000);
        ce_chk(16'h0000, 16'h0000);

        settle(11'h7FF);
        ce_chk(16'h0100, 16'hFFFF);
        ce_chk(16'h001F, 16'hFFFF);
        ce_chk(16'h0000, 16'hFFE0);
        ce_chk(16'h0010, 16'hFFF0);

        settle(11'h400);
        mute = 1'b1;
        ce_chk(16'h0050, 16'h0050);
        mute = 1'b0;
        ce_chk(16'h0050, 16'h8050);

        enable = 1'b0;
        idle(1);
        ce_chk(16'h0050, 16'h0050);
        enable = 1'b1;
        idle(1);
        repeat (7) pulse(11'h200);
        exp_level = 11'h200;
        exp_valid = 1'b1;
        enable = 1'b0;
        advance();
        enable = 1'b1;
        idle(2);
        ce_chk(16'h0000, 16'h0000);
        scan(11'h010);
        idle(1);
        ce_mdl(16'h0000);

        ce_mdl(16'h4000);
        idle(2);
        repeat (5) pulse(11'h300);
        reset_n = 1'b0;
        #2;
        chk("async_rst_out", audio_out, 16'h0000);
        chk("async_rst_valid", 16'(audio_valid), 16'h0000);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        scan(11'h7FF);
        idle(1);
        ce_mdl(16'h0000);

        idle(4);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
